// File: rtl/mi_regfile_pkg.sv
// rtl/mi_regfile_pkg.sv - shared sizes and types for the multi-ported register file
//
// Purpose: default geometry of the integer register file and the address/data
// types used by mi_regfile and mi_scoreboard.
// Ports: none (package).
package mi_regfile_pkg;

  localparam int REG_DW_DEF = 32;  // register width
  localparam int REG_AW_DEF = 5;   // address width, 2**REG_AW entries
  localparam int NR_RD_DEF  = 4;   // read ports, two per issue slot
  localparam int NR_WR_DEF  = 2;   // write ports and reservation ports

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;
  typedef logic [REG_DW_DEF-1:0] reg_data_t;

  // Hard-wired zero register: reads zero, never busy, ignores writes.
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/mi_scoreboard.sv
// rtl/mi_scoreboard.sv - per-register busy bits with reserve/flush/writeback priority
//
// Purpose: tracks which registers have an issued but not yet written-back
// producer, and exposes the registered busy bit on NR_RD lookup ports.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all bits)
//   wb_en, wb_addr  writeback ports, clear the busy bit of their address
//   iss_en, iss_addr reservation ports, set the busy bit of their address
//   flush           clear every busy bit
//   lk_addr         lookup addresses, one per read port
//   lk_busy         registered busy bit of each lookup address
module mi_scoreboard
  import mi_regfile_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int NR_RD  = NR_RD_DEF,
  parameter int NR_WR  = NR_WR_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR_WR-1:0]        wb_en,
  input  logic [NR_WR*REG_AW-1:0] wb_addr,
  input  logic [NR_WR-1:0]        iss_en,
  input  logic [NR_WR*REG_AW-1:0] iss_addr,
  input  logic                    flush,
  input  logic [NR_RD*REG_AW-1:0] lk_addr,
  output logic [NR_RD-1:0]        lk_busy
);

  localparam int NREGS = 1 << REG_AW;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_n;

  // Applied lowest priority first so later steps override: writeback clear,
  // then flush, then reservation (a new producer always wins).
  always_comb begin
    busy_n = busy_q;
    for (int p = 0; p < NR_WR; p++) begin
      if (wb_en[p]) busy_n[wb_addr[p*REG_AW +: REG_AW]] = 1'b0;
    end
    if (flush) busy_n = '0;
    for (int p = 0; p < NR_WR; p++) begin
      if (iss_en[p]) busy_n[iss_addr[p*REG_AW +: REG_AW]] = 1'b1;
    end
    busy_n[REG_AW'(ZERO_REG)] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_n;
  end

  always_comb begin
    lk_busy = '0;
    for (int k = 0; k < NR_RD; k++) begin
      lk_busy[k] = busy_q[lk_addr[k*REG_AW +: REG_AW]];
    end
  end

endmodule

// File: rtl/mi_regfile.sv
// rtl/mi_regfile.sv - multi-ported register file with writeback bypass and busy scoreboard
//
// Purpose: NR_RD combinational read ports and NR_WR write ports over a
// 2**REG_AW x REG_DW array; optional same-cycle forwarding of writeback data;
// per-register pending-write tracking for issue hazard checks.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   wb_en_i/addr_i/data_i  writeback ports (flattened, port k at [k*W +: W])
//   iss_en_i/addr_i        destination reservation ports
//   flush_i                clear all busy bits
//   rd_en_i/addr_i         read ports
//   rd_data_o, rd_busy_o   combinational read data and busy flag
module mi_regfile
  import mi_regfile_pkg::*;
#(
  parameter int REG_DW = REG_DW_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int NR_RD  = NR_RD_DEF,
  parameter int NR_WR  = NR_WR_DEF,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR_WR-1:0]        wb_en_i,
  input  logic [NR_WR*REG_AW-1:0] wb_addr_i,
  input  logic [NR_WR*REG_DW-1:0] wb_data_i,
  input  logic [NR_WR-1:0]        iss_en_i,
  input  logic [NR_WR*REG_AW-1:0] iss_addr_i,
  input  logic                    flush_i,
  input  logic [NR_RD-1:0]        rd_en_i,
  input  logic [NR_RD*REG_AW-1:0] rd_addr_i,
  output logic [NR_RD*REG_DW-1:0] rd_data_o,
  output logic [NR_RD-1:0]        rd_busy_o
);

  localparam int NREGS = 1 << REG_AW;
  localparam logic [REG_AW-1:0] ZERO_A = REG_AW'(ZERO_REG);

  logic [REG_DW-1:0] mem [NREGS];
  logic [NR_RD-1:0]  sb_busy;

  // Ports are visited in ascending order, so the highest-index writer to a
  // shared address lands last and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NR_WR; p++) begin
        if (wb_en_i[p] && (wb_addr_i[p*REG_AW +: REG_AW] != ZERO_A)) begin
          mem[wb_addr_i[p*REG_AW +: REG_AW]] <= wb_data_i[p*REG_DW +: REG_DW];
        end
      end
    end
  end

  mi_scoreboard #(
    .REG_AW (REG_AW),
    .NR_RD  (NR_RD),
    .NR_WR  (NR_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en_i),
    .wb_addr  (wb_addr_i),
    .iss_en   (iss_en_i),
    .iss_addr (iss_addr_i),
    .flush    (flush_i),
    .lk_addr  (rd_addr_i),
    .lk_busy  (sb_busy)
  );

  // Read mux: array value and registered busy, overridden by a same-cycle
  // writeback to the same address when forwarding is enabled. A forwarded
  // value is by definition no longer pending, hence busy drops to 0.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NR_RD; k++) begin
      if (!rst && rd_en_i[k] && (rd_addr_i[k*REG_AW +: REG_AW] != ZERO_A)) begin
        rd_data_o[k*REG_DW +: REG_DW] = mem[rd_addr_i[k*REG_AW +: REG_AW]];
        rd_busy_o[k] = sb_busy[k];
        if (BYPASS != 0) begin
          for (int p = 0; p < NR_WR; p++) begin
            if (wb_en_i[p] &&
                (wb_addr_i[p*REG_AW +: REG_AW] == rd_addr_i[k*REG_AW +: REG_AW])) begin
              rd_data_o[k*REG_DW +: REG_DW] = wb_data_i[p*REG_DW +: REG_DW];
              rd_busy_o[k] = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/mi_regfile.md
# mi_regfile

Multi-ported integer register file with write-to-read bypass and a per-register busy scoreboard, for the dual-issue core. Sits between decode/issue (read ports, destination reservation) and writeback (write ports). Generalises the single-issue register file to NR_RD read ports and NR_WR write ports, and adds pending-write tracking for hazard detection.

## Interface
- REG_DW, 32, register width
- REG_AW, 5, register address width; 2**REG_AW entries
- NR_RD, 4, read ports (2 per issue slot)
- NR_WR, 2, write ports and reservation ports
- BYPASS, 1, 1 = same-cycle writeback data forwarded to reads; 0 = no forwarding
- Port vectors are flattened; port k occupies bits [k*W +: W].
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- wb_en_i  in  NR_WR  write enable per port
- wb_addr_i  in  NR_WR*REG_AW  write address
- wb_data_i  in  NR_WR*REG_DW  write data
- iss_en_i  in  NR_WR  reserve destination (mark busy)
- iss_addr_i  in  NR_WR*REG_AW  destination to reserve
- flush_i  in  1  clear all busy bits (pipeline flush)
- rd_en_i  in  NR_RD  read enable per port
- rd_addr_i  in  NR_RD*REG_AW  read address
- rd_data_o  out  NR_RD*REG_DW  read data (combinational)
- rd_busy_o  out  NR_RD  register has a pending writer (combinational)

## Operation
- Storage: 2**REG_AW × REG_DW registers plus 2**REG_AW busy bits. Entry 0 reads zero, is never busy, ignores writes and reservations.
- Write: on posedge, each port with wb_en_i=1 and addr≠0 updates its entry. Same address on several ports: highest port index wins.
- Writeback clears the busy bit of its address.
- Reservation: iss_en_i=1, addr≠0 sets the busy bit.
- Same-cycle priority on one busy bit: iss set > flush clear > wb clear (a new producer always wins).
- flush_i clears every busy bit; register contents untouched; writes in the same cycle still commit.
- Read port k: rst=1 or rd_en_i[k]=0 → data 0, busy 0. Otherwise data = entry; if BYPASS=1 and any wb port writes the same non-zero address this cycle, data = wb_data of the highest-index matching port and busy = 0.
- BYPASS=0: read returns the old value; busy reflects the registered bit.
- Reservation does not affect same-cycle reads.

## Timing
- Reset: all entries 0, all busy bits 0 at the first posedge with rst=1; rd_data_o = 0 and rd_busy_o = 0 while rst=1. rst overrides wb, iss, flush.
- Read: 0-cycle combinational.
- Write: visible at the array the cycle after wb_en_i; same cycle via bypass.
- Busy set/clear visible the cycle after iss_en_i/wb_en_i (write-port bypass clears busy same cycle).
- rst asserted mid-operation discards all pending reservations; no partial state survives.

## Structure
- Package mi_regfile_pkg: REG_DW/REG_AW defaults, NR_RD/NR_WR defaults, reg_addr_t/reg_data_t typedefs, ZERO_REG constant.
- Sub-module mi_scoreboard: busy-bit array with set/clear/flush priority and NR_RD lookup ports; data array and bypass mux stay in mi_regfile.

## Test plan
- Reset then read x1..x31 on all ports → data 0, busy 0; write x0=0xDEADBEEF → x0 still reads 0.
- Port0 writes x5=0x11, port1 writes x5=0x22 same cycle → next cycle x5 reads 0x22; with BYPASS=1 same-cycle read of x5 returns 0x22, busy 0.
- iss x7 → next cycle rd_busy=1; wb x7=0x55 → same cycle (bypass) data 0x55 busy 0, next cycle busy 0.
- Same cycle iss x9 and wb x9=0x1 → x9 data 0x1, busy stays 1.
- Reserve x3, x4; flush_i with iss x4 → next cycle x3 busy 0, x4 busy 1.
- Write x2=0xABCD, reserve x2, assert rst one cycle → x2 reads 0, busy 0; BYPASS=0 build: same-cycle read of written x6 returns old value.
